// File: rtl/mac3_accumulator_pkg.sv
// mac3_accumulator_pkg: shared constants and FSM state encoding for the
// mac3 multiply-accumulate slice.
//   OP_W    - operand width of the 3x3 multiplier
//   PROD_W  - product width of the 3x3 multiplier
//   state_t - run-control FSM states (IDLE=0, ACCUM=1, DRAIN=2, DONE=3)
package mac3_accumulator_pkg;

  localparam int OP_W   = 3;
  localparam int PROD_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mac3_accumulator_multiplier.sv
// multiplier: 3x3 unsigned array multiplier, purely combinational.
//   A [2:0] - multiplicand
//   B [2:0] - multiplier
//   P [5:0] - product A*B
module multiplier
  import mac3_accumulator_pkg::*;
(
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
  output logic [PROD_W-1:0] P
);

  logic [PROD_W-1:0] pp0_s;
  logic [PROD_W-1:0] pp1_s;
  logic [PROD_W-1:0] pp2_s;

  // Partial-product rows of the array, each pre-shifted to its weight.
  assign pp0_s = {3'b000, A & {3{B[0]}}};
  assign pp1_s = {2'b00, A & {3{B[1]}}, 1'b0};
  assign pp2_s = {1'b0, A & {3{B[2]}}, 2'b00};

  assign P = pp0_s + pp1_s + pp2_s;

endmodule

// File: rtl/mac3_accumulator.sv
// mac3_accumulator: accepts LEN operand pairs over a valid/ready handshake,
// multiplies each registered pair with the 3x3 multiplier and sums the
// products into an ACC_W-bit accumulator; the dot product is then offered
// behind an output valid/ready handshake.
//   clk, reset           - clock, synchronous active-high reset
//   start                - begin a run (honoured only in IDLE)
//   in_valid / in_ready  - operand handshake, a/b are the operands
//   busy                 - high whenever the FSM is not in IDLE
//   out_valid / out_ready- result handshake
//   result, ovf          - accumulated sum mod 2^ACC_W, sticky carry-out flag
module mac3_accumulator
  import mac3_accumulator_pkg::*;
#(
  parameter int LEN   = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       a,
  input  logic [2:0]       b,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             ovf
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  state_t            state_r;
  state_t            next_state_s;
  logic              stage_valid_r;
  logic [CNT_W-1:0]  count_r;
  logic [OP_W-1:0]   a_stage_r;
  logic [OP_W-1:0]   b_stage_r;
  logic [PROD_W-1:0] prod_s;
  logic [ACC_W-1:0]  acc_r;
  logic              ovf_r;
  logic [ACC_W:0]    sum_s;
  logic              hs_s;
  logic              start_run_s;
  logic              in_ready_r;
  logic              busy_r;
  logic              out_valid_r;

  // in_ready is a pure function of state, so the handshake can be decoded
  // from state without going through the output register.
  assign hs_s        = in_valid && (state_r == ACCUM);
  assign start_run_s = start && (state_r == IDLE);

  // Extra top bit captures the carry-out used for the sticky overflow.
  assign sum_s = {1'b0, acc_r} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_s};

  multiplier u_multiplier (
    .A (a_stage_r),
    .B (b_stage_r),
    .P (prod_s)
  );

  // Next-state decode for the run-control FSM.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = ACCUM;
        else       next_state_s = IDLE;
      end
      ACCUM: begin
        // The LEN-th handshake ends the input phase, so count never wraps.
        if (hs_s && (count_r == LAST_CNT)) next_state_s = DRAIN;
        else                               next_state_s = ACCUM;
      end
      DRAIN:   next_state_s = DONE;
      DONE: begin
        if (out_ready) next_state_s = IDLE;
        else           next_state_s = DONE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= next_state_s;
  end

  // Status outputs registered from the next state so they track the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (next_state_s == ACCUM);
      busy_r      <= (next_state_s != IDLE);
      out_valid_r <= (next_state_s == DONE);
    end
  end

  // Operand stage: captures each accepted pair for the multiplier.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_stage_r     <= 3'd0;
      b_stage_r     <= 3'd0;
      stage_valid_r <= 1'b0;
    end else if (hs_s) begin
      a_stage_r     <= a;
      b_stage_r     <= b;
      stage_valid_r <= 1'b1;
    end else begin
      stage_valid_r <= 1'b0;
    end
  end

  // Handshake counter, cleared when a run starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (start_run_s) begin
      count_r <= {CNT_W{1'b0}};
    end else if (hs_s) begin
      count_r <= count_r + CNT_W'(1);
    end
  end

  // Accumulator and sticky overflow; the product lands one cycle after
  // its handshake, which is why DRAIN exists.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r <= {ACC_W{1'b0}};
      ovf_r <= 1'b0;
    end else if (start_run_s) begin
      acc_r <= {ACC_W{1'b0}};
      ovf_r <= 1'b0;
    end else if (stage_valid_r) begin
      acc_r <= sum_s[ACC_W-1:0];
      ovf_r <= ovf_r | sum_s[ACC_W];
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign result    = acc_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_mac3_accumulator.sv
// tb_mac3_accumulator: scoreboard bench for mac3_accumulator. Three
// instances cover LEN=4, LEN=6 and LEN=1 (all ACC_W=8); expected results are
// pushed when a run's operands are driven and popped when out_valid rises.
module tb_mac3_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_v     [3];
  logic       start_v     [3];
  logic       in_valid_v  [3];
  logic       out_ready_v [3];
  logic [2:0] a_v         [3];
  logic [2:0] b_v         [3];
  logic       in_ready_v  [3];
  logic       busy_v      [3];
  logic       out_valid_v [3];
  logic       ovf_v       [3];
  logic [7:0] result_v    [3];

  mac3_accumulator #(.LEN(4), .ACC_W(8)) u_len4 (
    .clk(clk), .reset(reset_v[0]), .start(start_v[0]), .in_valid(in_valid_v[0]),
    .in_ready(in_ready_v[0]), .a(a_v[0]), .b(b_v[0]), .busy(busy_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .result(result_v[0]), .ovf(ovf_v[0]));

  mac3_accumulator #(.LEN(6), .ACC_W(8)) u_len6 (
    .clk(clk), .reset(reset_v[1]), .start(start_v[1]), .in_valid(in_valid_v[1]),
    .in_ready(in_ready_v[1]), .a(a_v[1]), .b(b_v[1]), .busy(busy_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .result(result_v[1]), .ovf(ovf_v[1]));

  mac3_accumulator #(.LEN(1), .ACC_W(8)) u_len1 (
    .clk(clk), .reset(reset_v[2]), .start(start_v[2]), .in_valid(in_valid_v[2]),
    .in_ready(in_ready_v[2]), .a(a_v[2]), .b(b_v[2]), .busy(busy_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .result(result_v[2]), .ovf(ovf_v[2]));

  typedef struct {
    logic [7:0] res;
    logic       ovf;
  } exp_t;

  exp_t       exp_q[$];
  int         tests_run = 0;
  int         n_fail    = 0;
  logic [2:0] pa [8];
  logic [2:0] pb [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full run on instance d using pa/pb[0..n-1]. gap_max>0 inserts 1..gap_max
  // idle cycles between pairs; hold = cycles out_ready stays low in DONE;
  // mid_start pulses start alongside the second pair.
  task automatic do_run(input int d, input int n, input int gap_max,
                        input int hold, input bit mid_start, input string name);
    int   s;
    int   cyc;
    exp_t e;
    s = 0;
    for (int i = 0; i < n; i++) s += int'(pa[i]) * int'(pb[i]);
    e.res = 8'(s % 256);
    e.ovf = (s >= 256);
    exp_q.push_back(e);

    start_v[d] = 1'b1;
    step();
    start_v[d] = 1'b0;
    tests_run++;
    if (busy_v[d] !== 1'b1 || in_ready_v[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s start: busy=%b in_ready=%b, expected 1 1", name, busy_v[d], in_ready_v[d]);
    end

    for (int i = 0; i < n; i++) begin
      if (i > 0 && gap_max > 0) begin
        in_valid_v[d] = 1'b0;
        repeat ($urandom_range(1, gap_max)) step();
      end
      in_valid_v[d] = 1'b1;
      a_v[d] = pa[i];
      b_v[d] = pb[i];
      if (mid_start && i == 1) start_v[d] = 1'b1;
      step();
      start_v[d] = 1'b0;
    end
    in_valid_v[d] = 1'b0;

    cyc = 1;
    while (out_valid_v[d] !== 1'b1 && cyc < 10) begin
      step();
      cyc++;
    end
    tests_run++;
    if (cyc != 2) begin
      n_fail++;
      $display("FAIL %s latency: out_valid after %0d edges, expected 2", name, cyc);
    end
    if (out_valid_v[d] !== 1'b1) begin
      out_ready_v[d] = 1'b1;
      step();
      out_ready_v[d] = 1'b0;
      return;
    end

    e = exp_q.pop_front();
    tests_run++;
    if (result_v[d] !== e.res || ovf_v[d] !== e.ovf) begin
      n_fail++;
      $display("FAIL %s result: got %0d ovf=%b, expected %0d ovf=%b",
               name, result_v[d], ovf_v[d], e.res, e.ovf);
    end

    out_ready_v[d] = 1'b0;
    for (int h = 0; h < hold; h++) begin
      step();
      tests_run++;
      if (out_valid_v[d] !== 1'b1 || result_v[d] !== e.res || ovf_v[d] !== e.ovf) begin
        n_fail++;
        $display("FAIL %s hold: out_valid=%b result=%0d ovf=%b, expected 1 %0d %b",
                 name, out_valid_v[d], result_v[d], ovf_v[d], e.res, e.ovf);
      end
    end

    out_ready_v[d] = 1'b1;
    step();
    out_ready_v[d] = 1'b0;
    tests_run++;
    if (out_valid_v[d] !== 1'b0 || busy_v[d] !== 1'b0 || in_ready_v[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s release: out_valid=%b busy=%b in_ready=%b, expected 0 0 0",
               name, out_valid_v[d], busy_v[d], in_ready_v[d]);
    end
  endtask

  task automatic check_zero(input int d, input string name);
    tests_run++;
    if ({in_ready_v[d], busy_v[d], out_valid_v[d], ovf_v[d], result_v[d]} !== 12'h000) begin
      n_fail++;
      $display("FAIL %s: in_ready=%b busy=%b out_valid=%b ovf=%b result=%0d, expected all 0",
               name, in_ready_v[d], busy_v[d], out_valid_v[d], ovf_v[d], result_v[d]);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      reset_v[d] = 1'b1;  start_v[d] = 1'b0;  in_valid_v[d] = 1'b0;
      out_ready_v[d] = 1'b0;  a_v[d] = 3'd0;  b_v[d] = 3'd0;
    end
    step();
    step();
    for (int d = 0; d < 3; d++) check_zero(d, "reset");
    for (int d = 0; d < 3; d++) reset_v[d] = 1'b0;
    step();
  endtask

  task automatic load_basic();
    pa[0] = 3'd3; pb[0] = 3'd5;
    pa[1] = 3'd7; pb[1] = 3'd7;
    pa[2] = 3'd2; pb[2] = 3'd6;
    pa[3] = 3'd0; pb[3] = 3'd4;
  endtask

  task automatic test_basic();
    load_basic();
    do_run(0, 4, 0, 0, 1'b0, "basic");
  endtask

  task automatic test_gaps();
    load_basic();
    do_run(0, 4, 3, 5, 1'b0, "gaps");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 6; i++) begin
      pa[i] = 3'd7;
      pb[i] = 3'd7;
    end
    do_run(1, 6, 0, 2, 1'b0, "wrap");
  endtask

  task automatic test_reset_midrun();
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid_v[0] = 1'b1; a_v[0] = 3'd7; b_v[0] = 3'd7;
      step();
    end
    in_valid_v[0] = 1'b0;
    reset_v[0] = 1'b1;
    step();
    check_zero(0, "reset_midrun");
    reset_v[0] = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      pa[i] = 3'd1;
      pb[i] = 3'd1;
    end
    do_run(0, 4, 1, 0, 1'b0, "after_reset");
  endtask

  task automatic test_idle_ignore();
    // Previous run left acc=4; IDLE traffic must neither accept nor add.
    in_valid_v[0] = 1'b1; a_v[0] = 3'd7; b_v[0] = 3'd7;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (in_ready_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || result_v[0] !== 8'd4) begin
        n_fail++;
        $display("FAIL idle_ignore: in_ready=%b busy=%b result=%0d, expected 0 0 4",
                 in_ready_v[0], busy_v[0], result_v[0]);
      end
    end
    in_valid_v[0] = 1'b0;
    load_basic();
    do_run(0, 4, 0, 0, 1'b1, "mid_start");
  endtask

  task automatic test_len1();
    pa[0] = 3'd7;
    pb[0] = 3'd7;
    do_run(2, 1, 0, 1, 1'b0, "len1");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_wrap();
    test_reset_midrun();
    test_idle_ignore();
    test_len1();
    $display("[TB] %0d tests run, %0d failed", tests_run, n_fail);
    $finish;
  end

endmodule
